// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, requests to send, then shifts a byte out on device clocks.
module ps2_host_tx #(
  parameter int CLK_FREQ = 28_000_000
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out
);

  localparam int T_INH = CLK_FREQ / 10000;
  localparam int T_RTS = CLK_FREQ / 100000;
  localparam int T_TO  = CLK_FREQ / 1000 * 15;

  localparam logic [18:0] INH_LAST = 19'(T_INH - 1);
  localparam logic [18:0] RTS_LAST = 19'(T_RTS - 1);
  localparam logic [18:0] TO_LAST  = 19'(T_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic        ck_s1_q, ck_s1_d;
  logic        ck_s2_q, ck_s2_d;
  logic        ck_prev_q, ck_prev_d;
  logic        dt_s1_q, dt_s1_d;
  logic        dt_s2_q, dt_s2_d;
  logic        fall_q, fall_d;
  logic [18:0] tmr_q, tmr_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        clk_o_q, clk_o_d;
  logic        dat_o_q, dat_o_d;
  logic [3:0]  bit_inc;
  logic        to_hit;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ck_s1_q   <= 1'b1;
      ck_s2_q   <= 1'b1;
      ck_prev_q <= 1'b1;
      dt_s1_q   <= 1'b1;
      dt_s2_q   <= 1'b1;
      fall_q    <= 1'b0;
      tmr_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_o_q   <= 1'b1;
      dat_o_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      ck_s1_q   <= ck_s1_d;
      ck_s2_q   <= ck_s2_d;
      ck_prev_q <= ck_prev_d;
      dt_s1_q   <= dt_s1_d;
      dt_s2_q   <= dt_s2_d;
      fall_q    <= fall_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_o_q   <= clk_o_d;
      dat_o_q   <= dat_o_d;
    end
  end

  always_comb begin
    ck_s1_d   = ps2_clk_in;
    ck_s2_d   = ck_s1_q;
    ck_prev_d = ck_s2_q;
    dt_s1_d   = ps2_dat_in;
    dt_s2_d   = dt_s1_q;
    fall_d    = ck_prev_q & ~ck_s2_q;
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    data_d    = data_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    err_d     = err_q;
    clk_o_d   = 1'b1;
    dat_o_d   = dat_o_q;
    bit_inc   = (bit_q == 4'hf) ? bit_q : bit_q + 4'd1;
    to_hit    = (tmr_q == TO_LAST);

    unique case (state_q)
      S_IDLE: begin
        dat_o_d = 1'b1;
        if (tx_valid) begin
          state_d = S_INHIBIT;
          data_d  = tx_data;
          err_d   = 1'b0;
          nack_d  = 1'b0;
          tmr_d   = '0;
          bit_d   = '0;
        end
      end
      S_INHIBIT: begin
        dat_o_d = 1'b1;
        tmr_d   = tmr_q + 19'd1;
        if (tmr_q == INH_LAST) begin
          state_d = S_RTS;
          tmr_d   = '0;
          dat_o_d = 1'b0;
        end
      end
      S_RTS: begin
        tmr_d = tmr_q + 19'd1;
        if (tmr_q == RTS_LAST) begin
          state_d = S_SEND;
          tmr_d   = '0;
        end
      end
      S_SEND: begin
        tmr_d = tmr_q + 19'd1;
        if (to_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          dat_o_d = 1'b1;
          tmr_d   = '0;
        end else if (fall_q) begin
          bit_d = bit_inc;
          unique case (1'b1)
            bit_q < 4'd8:  dat_o_d = data_q[bit_q[2:0]];
            bit_q == 4'd8: dat_o_d = ~^data_q;
            default: begin
              dat_o_d = 1'b1;
              state_d = S_ACK;
            end
          endcase
        end
      end
      S_ACK: begin
        tmr_d = tmr_q + 19'd1;
        if (to_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          dat_o_d = 1'b1;
          tmr_d   = '0;
        end else if (fall_q) begin
          bit_d   = bit_inc;
          nack_d  = dt_s2_q;
          state_d = S_RELEASE;
          tmr_d   = '0;
        end
      end
      S_RELEASE: begin
        dat_o_d = 1'b1;
        if (ck_s2_q && dt_s2_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = nack_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        dat_o_d = 1'b1;
      end
    endcase

    // clock is only ever pulled low while inhibiting or requesting
    clk_o_d = ~((state_d == S_INHIBIT) | (state_d == S_RTS));
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_out = clk_o_q;
  assign ps2_dat_out = dat_o_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench for ps2_host_tx
// against a cycle-stepped PS/2 device model.
module tb_ps2_host_tx;

  localparam int CF    = 1_000_000;
  localparam int T_INH = CF / 10000;
  localparam int T_RTS = CF / 100000;
  localparam int T_TO  = CF / 1000 * 15;
  localparam int HALF  = 40;

  localparam int M_ACK   = 0;
  localparam int M_NACK  = 1;
  localparam int M_NOCLK = 2;

  logic       clk28    = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_out, ps2_dat_out;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;

  wire clk_line = ps2_clk_out & dev_clk;
  wire dat_line = ps2_dat_out & dev_dat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         mode;
  } exp_t;

  typedef struct {
    logic [9:0] bits;
    logic       start;
    int         lo;
    int         rts;
    int         send_cyc;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];

  ps2_host_tx #(.CLK_FREQ(CF)) dut (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_out(ps2_clk_out),
    .ps2_dat_out(ps2_dat_out)
  );

  always #5 clk28 = ~clk28;
  always @(posedge clk28) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  // device model: measures inhibit/RTS, then clocks 11 pulses
  int   dev_ph   = 0;
  int   dev_mode = M_ACK;
  int   dev_t    = 0;
  int   dev_bits = 0;
  int   dk, dr;
  got_t cur;

  initial begin
    forever begin
      step();
      if (!rst_n) begin
        dev_ph  = 0;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
      end else begin
        case (dev_ph)
          0: if (ps2_clk_out == 1'b0) begin
            dev_ph  = 1;
            cur.lo  = 1;
            cur.rts = ps2_dat_out ? 0 : 1;
          end
          1: if (ps2_clk_out == 1'b0) begin
            cur.lo++;
            if (!ps2_dat_out) cur.rts++;
          end else begin
            cur.send_cyc = cyc;
            cur.start    = dat_line;
            cur.bits     = '0;
            dev_t        = 0;
            dev_bits     = 0;
            if (dev_mode == M_NOCLK) begin
              got_q.push_back(cur);
              dev_ph = 0;
            end else begin
              dev_ph = 2;
            end
          end
          default: begin
            dev_t++;
            if (dev_t >= 22 * HALF) begin
              dev_clk = 1'b1;
              dev_dat = 1'b1;
              got_q.push_back(cur);
              dev_ph = 0;
            end else begin
              dk = dev_t / (2 * HALF);
              dr = dev_t % (2 * HALF);
              if (dr == 0 && dk >= 1) begin
                cur.bits[dk-1] = dat_line;
                dev_bits++;
              end
              if (dk == 10 && dr == HALF / 2 && dev_mode == M_ACK)
                dev_dat = 1'b0;
              dev_clk = (dr < HALF);
            end
          end
        endcase
      end
    end
  end

  // monitor: pops expectation on every tx_done
  initial begin
    exp_t e;
    got_t g;
    forever begin
      step();
      if (rst_n && tx_done) begin
        chk("exp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_err", tx_err, e.mode != M_ACK);
          chk("busy_at_done", busy, 0);
          chk("dev_record", got_q.size() > 0, 1);
          if (got_q.size() > 0) begin
            g = got_q.pop_front();
            chk("clk_low_cycles", g.lo, T_INH + T_RTS);
            chk("rts_cycles", g.rts, T_RTS);
            chk("start_bit", g.start, 0);
            if (e.mode == M_NOCLK) begin
              chk("timeout_cycles", cyc - g.send_cyc, T_TO);
              chk("lines_at_timeout",
                  {ps2_clk_out, ps2_dat_out}, 2'b11);
            end else begin
              chk("data_byte", g.bits[7:0], e.data);
              chk("parity_bit", g.bits[8],
                  ($countones(e.data) % 2) == 0);
              chk("stop_bit", g.bits[9], 1);
            end
          end
          step();
          chk("done_pulse_width", tx_done, 0);
          chk("err_held", tx_err, e.mode != M_ACK);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] d,
                       input int mode,
                       input bit poke);
    int n;
    exp_t e;
    n = 0;
    while (!tx_ready && n < 5000) begin
      step();
      n++;
    end
    chk("ready_wait", tx_ready, 1);
    dev_mode = mode;
    e.data   = d;
    e.mode   = mode;
    exp_q.push_back(e);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("ready_after_accept", tx_ready, 0);
    chk("busy_after_accept", busy, 1);
    chk("err_cleared", tx_err, 0);
    if (poke) begin
      repeat (3) step();
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < T_TO + 5000) begin
      step();
      n++;
    end
    chk("done_in_time", exp_q.size(), 0);
    repeat (4) step();
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    logic [7:0] d;

    tx_valid = 1'b1;
    tx_data  = 8'hED;
    dev_mode = M_ACK;
    repeat (3) step();
    chk("rst_clk_out", ps2_clk_out, 1);
    chk("rst_dat_out", ps2_dat_out, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);

    e.data = 8'hED;
    e.mode = M_ACK;
    exp_q.push_back(e);
    @(negedge clk28);
    rst_n = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("first_edge_accept", tx_ready, 0);
    chk("first_edge_busy", busy, 1);
    wait_done();

    issue(8'h01, M_ACK, 1'b0);
    wait_done();

    issue(8'($urandom), M_NACK, 1'b0);
    wait_done();

    issue(8'($urandom), M_ACK, 1'b1);
    wait_done();

    issue(8'($urandom), M_NOCLK, 1'b0);
    wait_done();

    dev_bits = 0;
    issue(8'h00, M_ACK, 1'b0);
    n = 0;
    while (dev_bits < 4 && n < 5000) begin
      step();
      n++;
    end
    chk("bits_before_reset", dev_bits >= 4, 1);
    chk("dat_low_before_reset", ps2_dat_out, 0);
    @(negedge clk28);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_clk_released", ps2_clk_out, 1);
    chk("reset_dat_released", ps2_dat_out, 1);
    chk("reset_no_done", tx_done, 0);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    repeat (5) step();
    got_q.delete();
    @(negedge clk28);
    rst_n = 1'b1;
    repeat (3) step();

    issue(8'hF4, M_ACK, 1'b0);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      issue(d, ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, 1'b0);
      wait_done();
    end

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("dev_queue_empty", got_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
